// File: rtl/hmmm_seq_alu.sv
// hmmm_seq_alu: multi-cycle ALU for the Hmmm datapath with shift-add multiply and floor div/mod
module hmmm_seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] tmp1,
  input  logic [WIDTH-1:0] tmp2,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             div_zero,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, ovf_q, ovf_d, dz_q, dz_d, long_q, long_d;
  logic [WIDTH-1:0] mag1, mag2, ma, mb, dr, dq, qs, rs, qf, rf;
  logic [WIDTH:0] add_s, sub_s, msum, dt;
  logic [2*WIDTH-1:0] mprod, mprod_s;
  logic long_op, last, neg_s, dge, fix, mover;
  assign mag1 = tmp1[WIDTH-1] ? -tmp1 : tmp1;
  assign mag2 = tmp2[WIDTH-1] ? -tmp2 : tmp2;
  assign add_s = {1'b0, tmp1} + {1'b0, tmp2};
  assign sub_s = {1'b0, tmp1} + {1'b0, ~tmp2} + (WIDTH+1)'(1);
  assign long_op = op == 3'd3 || ((op == 3'd4 || op == 3'd5) && tmp2 != '0);
  assign last = cnt_q == CW'(WIDTH - 1);
  assign neg_s = a_q[WIDTH-1] ^ b_q[WIDTH-1];
  assign ma = a_q[WIDTH-1] ? -a_q : a_q;
  assign mb = b_q[WIDTH-1] ? -b_q : b_q;
  // hi:lo holds the partial product while multiplying, remainder:quotient while dividing
  assign msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, ma} : '0);
  assign mprod = {msum, lo_q[WIDTH-1:1]};
  assign mprod_s = neg_s ? -mprod : mprod;
  assign mover = !(&mprod_s[2*WIDTH-1:WIDTH-1] || ~|mprod_s[2*WIDTH-1:WIDTH-1]);
  assign dt = {hi_q, lo_q[WIDTH-1]};
  assign dge = dt >= {1'b0, mb};
  assign dr = dge ? WIDTH'(dt - {1'b0, mb}) : dt[WIDTH-1:0];
  assign dq = {lo_q[WIDTH-2:0], dge};
  assign qs = neg_s ? -dq : dq;
  assign rs = a_q[WIDTH-1] ? -dr : dr;
  assign fix = hi_q != '0 && neg_s;
  assign qf = fix ? lo_q - WIDTH'(1) : lo_q;
  assign rf = fix ? hi_q + b_q : hi_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      long_q  <= long_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !start ? IDLE : op == 3'd3 ? MUL : long_op ? DIV : DONE;
      MUL:     state_d = last ? DONE : MUL;
      DIV:     state_d = last ? FIX : DIV;
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q + CW'(1);
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    long_d  = long_q;
    case (state_q)
      IDLE: if (start) begin
        op_d   = op;
        a_d    = tmp1;
        b_d    = tmp2;
        cnt_d  = '0;
        hi_d   = '0;
        lo_d   = op == 3'd3 ? mag2 : mag1;
        long_d = long_op;
        if (!long_op) begin
          res_d   = op == 3'd0 ? add_s[WIDTH-1:0] : op == 3'd1 ? sub_s[WIDTH-1:0] :
                    op == 3'd2 ? -tmp2 : (op == 3'd4 || op == 3'd5) ? '0 : tmp1;
          carry_d = op == 3'd0 ? add_s[WIDTH] : op == 3'd1 ? sub_s[WIDTH] : 1'b0;
          ovf_d   = op == 3'd0 ? (tmp1[WIDTH-1] == tmp2[WIDTH-1] && add_s[WIDTH-1] != tmp1[WIDTH-1]) :
                    op == 3'd1 ? (tmp1[WIDTH-1] != tmp2[WIDTH-1] && sub_s[WIDTH-1] != tmp1[WIDTH-1]) :
                    op == 3'd2 && tmp2 == MIN;
          dz_d    = op == 3'd4 || op == 3'd5;
        end
      end
      MUL: begin
        hi_d = msum[WIDTH:1];
        lo_d = {msum[0], lo_q[WIDTH-1:1]};
        if (last) begin
          res_d   = mprod_s[WIDTH-1:0];
          carry_d = 1'b0;
          ovf_d   = mover;
          dz_d    = 1'b0;
        end
      end
      DIV: begin
        hi_d = last ? rs : dr;
        lo_d = last ? qs : dq;
      end
      FIX: begin
        res_d   = op_q == 3'd4 ? qf : rf;
        carry_d = 1'b0;
        ovf_d   = op_q == 3'd4 && a_q == MIN && b_q == '1;
        dz_d    = 1'b0;
      end
      default: ;
    endcase
  end
  always_comb begin
    result   = res_q;
    zero     = res_q == '0;
    carry    = carry_q;
    overflow = ovf_q;
    div_zero = dz_q;
    done     = state_q == DONE;
    busy     = state_q == MUL || state_q == DIV || state_q == FIX || (state_q == DONE && long_q);
  end
endmodule

// File: doc/hmmm_seq_alu.md
Name: hmmm_seq_alu

Overview:
- Parametrised multi-cycle ALU for the Hmmm datapath; next generation of the combinational single-cycle ALU.
- Adds iterative multiply, floor divide and modulo, a start/busy/done handshake and overflow/divide-by-zero flags.
- Sits between the register-file read latches (tmp1/tmp2) and the writeback mux.
- The control FSM issues `start` and stalls on `busy` until `done`.

Parameters:
- WIDTH, 16, operand/result width in bits (two's complement); must be >= 4.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- op  input  3  0 add, 1 sub, 2 neg(tmp2), 3 mul, 4 div, 5 mod, 6 copy(tmp1), 7 reserved (behaves as copy)
- tmp1  input  WIDTH  signed operand A (dividend / multiplicand)
- tmp2  input  WIDTH  signed operand B (divisor / multiplier)
- result  output  WIDTH  registered signed result, held until next accepted start
- zero  output  1  result == 0
- carry  output  1  unsigned carry-out (add/sub only, else 0)
- overflow  output  1  signed result not representable in WIDTH bits
- div_zero  output  1  div/mod with tmp2 == 0
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, result/flags valid

Behaviour:
- Reset (async, any state): state=IDLE; result=0, zero=1, carry=0, overflow=0, div_zero=0, busy=0, done=0. An in-flight operation is discarded.
- Operand capture: op, tmp1 and tmp2 are latched on the start edge; later changes to the inputs have no effect.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- IDLE + start:
  - op in {0,1,2,6,7}: compute, go to DONE.
  - op 3: go to MUL.
  - op 4/5 with tmp2 != 0: go to DIV.
  - op 4/5 with tmp2 == 0: go to DONE with result=0, div_zero=1.
- busy: high in MUL, DIV and FIX, and in the DONE cycle reached from them. Low in IDLE.
- start while not in IDLE: ignored, no queuing.
- DONE: done=1 for exactly one cycle, then IDLE. A start in the DONE cycle is ignored.
- Latency, with the start edge at cycle 0:
  - single-cycle ops and divide-by-zero: done in cycle 1.
  - mul: done in cycle WIDTH+1.
  - div/mod: done in cycle WIDTH+2.
- Back-to-back issue: a new start is accepted at the earliest in the cycle after done.
- Outputs update only on entry to DONE and hold otherwise. zero is derived from the registered result. Flags not applicable to an op are 0.
- add: result = A+B mod 2^WIDTH; carry = unsigned carry-out; overflow when the operand signs match and the result sign differs.
- sub: computed as A + ~B + 1; carry = that carry-out (1 means no borrow); overflow by the usual signed rule.
- neg: result = -B; overflow=1 only for B = MIN (result = MIN).
- mul:
  - MUL state: unsigned shift-add on operand magnitudes, one multiplier bit per cycle for WIDTH cycles, building a 2*WIDTH product.
  - Sign applied on the final step; result = low WIDTH bits.
  - overflow=1 when the upper WIDTH+1 bits of the signed product are not all equal.
- div/mod, floor (Hmmm/Python) semantics:
  - DIV state: restoring division on magnitudes, WIDTH cycles, giving truncated quotient q and remainder r.
  - q is negated if the operand signs differ; r takes the sign of A.
  - FIX state (1 cycle): if r != 0 and the signs of A and B differ, then q = q-1 and r = r+B.
  - div returns q; mod returns r. mod result always has the sign of B or is 0.
  - overflow=1 only for div MIN / -1 (result = MIN). mod MIN / -1 = 0 with overflow=0.
- Magnitude of MIN: handled as unsigned 2^(WIDTH-1) internally; no internal truncation.

Test Plan:
- Add, WIDTH=16: tmp1=-1, tmp2=-2, op=0, start -> done at cycle 1; result=-3, carry=1, overflow=0, zero=0, busy never high.
- Add overflow: 32767+2 -> result=-32767, overflow=1, carry=0. Sub: 3-3 -> result=0, zero=1, carry=1.
- Mul:
  - 300*200 -> done at cycle 17 with busy high cycles 1-17; result=-5536, overflow=1.
  - -7*6 -> result=-42, overflow=0.
- Div/mod:
  - div -7,2 -> result=-4 at cycle 18; mod -7,2 -> result=1; mod 7,-2 -> result=-1.
  - div -32768,-1 -> result=-32768, overflow=1.
  - div 5,0 -> done at cycle 1, result=0, div_zero=1, zero=1.
- Handshake: start mul 5*5; pulse start with op=0 at cycle 4 and change tmp1/tmp2 mid-operation -> ignored; result=25; exactly one done pulse.
- Reset mid-mul: assert reset at cycle 8 -> outputs immediately at reset values, no done pulse. A start issued after reset release (add 1+1) completes normally with result=2.
